ahb_sram_slave: RTL and testbench



---
 rtl/ahb_sram_slave_if.sv | 25 ++
 rtl/ahb_sram_slave.sv | 154 +++++++++++++++
 tb/tb_ahb_sram_slave.sv | 239 +++++++++++++++++++++++
 3 files changed

// File: rtl/ahb_sram_slave_if.sv
// AHB slave-side bus bundle for ahb_sram_slave: address/data phase inputs
// from the bus plus the slave's response signals.
interface ahb_sram_slave_if;
    logic        hsel;
    logic [31:0] haddr;
    logic [1:0]  htrans;
    logic        hwrite;
    logic [2:0]  hsize;
    logic [2:0]  hburst;
    logic [31:0] hwdata;
    logic        hready;
    logic [31:0] hrdata;
    logic        hreadyout;
    logic [1:0]  hresp;

    modport master (
        output hsel, haddr, htrans, hwrite, hsize, hburst, hwdata, hready,
        input  hrdata, hreadyout, hresp
    );

    modport slave (
        input  hsel, haddr, htrans, hwrite, hsize, hburst, hwdata, hready,
        output hrdata, hreadyout, hresp
    );
endinterface

// File: rtl/ahb_sram_slave.sv
// AHB responder backed by a word-organised SRAM with programmable wait states.
// Define AHB_SLV_WRITE_PROTECT_EN to add the wprot input that turns writes into ERROR.
module ahb_sram_slave #(
    parameter int ADDR_W      = 10,
    parameter int WAIT_STATES = 1
) (
    input  logic            hclk,
    input  logic            hreset_n,
`ifdef AHB_SLV_WRITE_PROTECT_EN
    input  logic            wprot,
`endif
    ahb_sram_slave_if.slave bus
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_ERR1,
        ST_ERR2
    } state_t;

    localparam logic [1:0] RESP_OKAY  = 2'b00;
    localparam logic [1:0] RESP_ERROR = 2'b01;
    localparam int         WS_INIT    = (WAIT_STATES > 0) ? WAIT_STATES - 1 : 0;

    state_t            state;
    logic [3:0]        wait_cnt;
    logic [ADDR_W+1:0] addr_q;
    logic              write_q;
    logic [2:0]        size_q;
    logic              xfer_q;
    logic              hreadyout_q;
    logic [1:0]        hresp_q;

    logic [31:0]       mem [2**ADDR_W];

    logic              sample;
    logic              illegal;
    logic              wr_protect;
    logic              final_cycle;
    logic              wr_en;
    logic [3:0]        byte_en;
    logic [ADDR_W-1:0] word_addr;
    logic              unused_inputs;

    // Only accept a new address phase while our own data phase is not stalling.
    assign sample = bus.hsel && bus.hready && bus.htrans[1] && hreadyout_q;

`ifdef AHB_SLV_WRITE_PROTECT_EN
    assign wr_protect = wprot && bus.hwrite;
`else
    assign wr_protect = 1'b0;
`endif

    always_comb begin
        illegal = wr_protect;
        case (bus.hsize)
            3'b000:  illegal = wr_protect;
            3'b001:  if (bus.haddr[0]) illegal = 1'b1;
            3'b010:  if (bus.haddr[1:0] != 2'b00) illegal = 1'b1;
            default: illegal = 1'b1;
        endcase
    end

    // An OKAY data phase ends in ST_IDLE with xfer_q set; errors never set xfer_q.
    always_ff @(posedge hclk or negedge hreset_n) begin
        if (!hreset_n) begin
            state       <= ST_IDLE;
            wait_cnt    <= '0;
            addr_q      <= '0;
            write_q     <= 1'b0;
            size_q      <= '0;
            xfer_q      <= 1'b0;
            hreadyout_q <= 1'b1;
            hresp_q     <= RESP_OKAY;
        end else if (sample) begin
            addr_q  <= bus.haddr[ADDR_W+1:0];
            write_q <= bus.hwrite;
            size_q  <= bus.hsize;
            if (illegal) begin
                state       <= ST_ERR1;
                xfer_q      <= 1'b0;
                hreadyout_q <= 1'b0;
                hresp_q     <= RESP_ERROR;
            end else if (WAIT_STATES > 0) begin
                state       <= ST_WAIT;
                wait_cnt    <= 4'(WS_INIT);
                xfer_q      <= 1'b1;
                hreadyout_q <= 1'b0;
                hresp_q     <= RESP_OKAY;
            end else begin
                state       <= ST_IDLE;
                xfer_q      <= 1'b1;
                hreadyout_q <= 1'b1;
                hresp_q     <= RESP_OKAY;
            end
        end else begin
            case (state)
                ST_IDLE: begin
                    xfer_q      <= 1'b0;
                    hreadyout_q <= 1'b1;
                    hresp_q     <= RESP_OKAY;
                end
                ST_WAIT: begin
                    if (wait_cnt == 4'd0) begin
                        state       <= ST_IDLE;
                        hreadyout_q <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt - 4'd1;
                    end
                end
                ST_ERR1: begin
                    state       <= ST_ERR2;
                    hreadyout_q <= 1'b1;
                end
                ST_ERR2: begin
                    state   <= ST_IDLE;
                    hresp_q <= RESP_OKAY;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign final_cycle = (state == ST_IDLE) && xfer_q;
    assign wr_en       = final_cycle && write_q;
    assign word_addr   = addr_q[ADDR_W+1:2];

    always_comb begin
        byte_en = 4'b0000;
        case (size_q)
            3'b000:  byte_en[addr_q[1:0]] = 1'b1;
            3'b001:  byte_en = addr_q[1] ? 4'b1100 : 4'b0011;
            3'b010:  byte_en = 4'b1111;
            default: byte_en = 4'b0000;
        endcase
    end

    // Array has no reset; lanes commit on the edge that closes the final data cycle.
    always_ff @(posedge hclk) begin
        if (wr_en) begin
            for (int i = 0; i < 4; i++) begin
                if (byte_en[i]) mem[word_addr][8*i +: 8] <= bus.hwdata[8*i +: 8];
            end
        end
    end

    assign bus.hrdata    = (final_cycle && !write_q) ? mem[word_addr] : 32'h0;
    assign bus.hreadyout = hreadyout_q;
    assign bus.hresp     = hresp_q;

    assign unused_inputs = ^{bus.hburst, bus.haddr[31:ADDR_W+2], bus.htrans[0]};

endmodule

// File: tb/tb_ahb_sram_slave.sv
// Scoreboard bench for ahb_sram_slave: one instance with one wait state and
// one with none, sharing stimulus; expectations come from a bench-side memory model.
module tb_ahb_sram_slave;

    localparam logic [1:0] T_IDLE = 2'b00;
    localparam logic [1:0] T_BUSY = 2'b01;
    localparam logic [1:0] T_NSEQ = 2'b10;
    localparam logic [1:0] T_SEQ  = 2'b11;

    typedef struct {
        string       tag;
        logic [31:0] data;
        logic [1:0]  resp;
        int          waits;
    } exp_t;

    logic        hclk     = 1'b0;
    logic        hreset_n = 1'b0;
    logic        use_ws0  = 1'b0;
    logic        hsel_d   = 1'b0;
    logic [31:0] haddr_d  = 32'h0;
    logic [1:0]  htrans_d = T_IDLE;
    logic        hwrite_d = 1'b0;
    logic [2:0]  hsize_d  = 3'b000;
    logic [2:0]  hburst_d = 3'b000;
    logic [31:0] hwdata_d = 32'h0;
`ifdef AHB_SLV_WRITE_PROTECT_EN
    logic        wprot_d  = 1'b0;
`endif

    logic        ready_m;
    logic [1:0]  resp_m;
    logic [31:0] rdata_m;

    int          n_vectors     = 0;
    int          n_miscompares = 0;
    exp_t        sb[$];
    logic [31:0] model [int];
    bit          in_data  = 1'b0;
    int          wait_cnt = 0;
    exp_t        done_e;
    logic [31:0] saved_word;

    ahb_sram_slave_if bus1 ();
    ahb_sram_slave_if bus0 ();

    assign bus1.hsel   = hsel_d & ~use_ws0;
    assign bus1.haddr  = haddr_d;
    assign bus1.htrans = htrans_d;
    assign bus1.hwrite = hwrite_d;
    assign bus1.hsize  = hsize_d;
    assign bus1.hburst = hburst_d;
    assign bus1.hwdata = hwdata_d;
    assign bus1.hready = bus1.hreadyout;

    assign bus0.hsel   = hsel_d & use_ws0;
    assign bus0.haddr  = haddr_d;
    assign bus0.htrans = htrans_d;
    assign bus0.hwrite = hwrite_d;
    assign bus0.hsize  = hsize_d;
    assign bus0.hburst = hburst_d;
    assign bus0.hwdata = hwdata_d;
    assign bus0.hready = bus0.hreadyout;

    assign ready_m = use_ws0 ? bus0.hreadyout : bus1.hreadyout;
    assign resp_m  = use_ws0 ? bus0.hresp     : bus1.hresp;
    assign rdata_m = use_ws0 ? bus0.hrdata    : bus1.hrdata;

    ahb_sram_slave #(.ADDR_W(10), .WAIT_STATES(1)) dut1 (
        .hclk     (hclk),
        .hreset_n (hreset_n),
`ifdef AHB_SLV_WRITE_PROTECT_EN
        .wprot    (wprot_d),
`endif
        .bus      (bus1.slave)
    );

    ahb_sram_slave #(.ADDR_W(10), .WAIT_STATES(0)) dut0 (
        .hclk     (hclk),
        .hreset_n (hreset_n),
`ifdef AHB_SLV_WRITE_PROTECT_EN
        .wprot    (wprot_d),
`endif
        .bus      (bus0.slave)
    );

    always #5 hclk = ~hclk;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        n_vectors++;
        if (actual !== expected) begin
            n_miscompares++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, actual, expected);
        end
    endtask

    // Drives one address phase, predicts its response, and holds it until hready accepts it.
    task automatic applyStimulus(input string tag, input logic [1:0] trans, input logic wr,
                                 input logic [31:0] addr, input logic [2:0] size,
                                 input logic [31:0] wdata, input logic [2:0] burst);
        exp_t        x;
        logic        bad;
        int          idx;
        logic [31:0] word;
        bit          accepted;
        int          guard;
        hsel_d   = (trans != T_IDLE);
        htrans_d = trans;
        hwrite_d = wr;
        haddr_d  = addr;
        hsize_d  = size;
        hburst_d = burst;
        if (trans[1]) begin
            bad  = (size > 3'd2) || ((addr & ((32'd1 << size) - 32'd1)) != 32'd0);
            idx  = int'(addr[11:2]);
            word = model.exists(idx) ? model[idx] : 32'h0;
            x.tag   = tag;
            x.resp  = bad ? 2'b01 : 2'b00;
            x.waits = bad ? 1 : (use_ws0 ? 0 : 1);
            x.data  = 32'h0;
            if (!bad && wr) begin
                for (int b = 0; b < 4; b++) begin
                    if (b >= int'(addr[1:0]) && b < int'(addr[1:0]) + (1 << size))
                        word[8*b +: 8] = wdata[8*b +: 8];
                end
                model[idx] = word;
            end else if (!bad) begin
                x.data = word;
            end
            sb.push_back(x);
        end
        accepted = 1'b0;
        guard    = 0;
        while (!accepted && guard < 64) begin
            @(negedge hclk);
            accepted = ready_m;
            @(posedge hclk);
            #1;
            guard++;
        end
        if (!accepted) checkOutput({tag, "_accept_timeout"}, 32'd0, 32'd1);
        if (trans[1] && wr) hwdata_d = wdata;
    endtask

    // Tracks data phases on the falling edge and retires scoreboard entries on hreadyout.
    always @(negedge hclk) begin
        if (!hreset_n) begin
            sb.delete();
            in_data  = 1'b0;
            wait_cnt = 0;
        end else begin
            if (in_data) begin
                if (!ready_m) begin
                    wait_cnt++;
                    if (sb.size() > 0) checkOutput({sb[0].tag, "_wait_resp"}, 32'(resp_m), 32'(sb[0].resp));
                end else if (sb.size() == 0) begin
                    checkOutput("sb_underflow", 32'd0, 32'd1);
                    in_data = 1'b0;
                end else begin
                    done_e = sb.pop_front();
                    checkOutput({done_e.tag, "_resp"},  32'(resp_m),   32'(done_e.resp));
                    checkOutput({done_e.tag, "_data"},  rdata_m,       done_e.data);
                    checkOutput({done_e.tag, "_waits"}, 32'(wait_cnt), 32'(done_e.waits));
                    in_data  = 1'b0;
                    wait_cnt = 0;
                end
            end
            if (!in_data && hsel_d && ready_m && htrans_d[1]) in_data = 1'b1;
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got no finish, expected finish");
        $fatal(1);
    end

    initial begin
        repeat (2) @(negedge hclk);
        checkOutput("in_reset_ready", 32'(ready_m), 32'd1);
        checkOutput("in_reset_resp",  32'(resp_m),  32'd0);
        checkOutput("in_reset_rdata", rdata_m,      32'd0);
        @(posedge hclk);
        #1 hreset_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge hclk);
            checkOutput("idle_ready", 32'(ready_m), 32'd1);
            checkOutput("idle_resp",  32'(resp_m),  32'd0);
            checkOutput("idle_rdata", rdata_m,      32'd0);
        end
        @(posedge hclk);
        #1;

        applyStimulus("wr_word",    T_NSEQ, 1'b1, 32'h10, 3'b010, 32'hDEADBEEF, 3'b000);
        applyStimulus("rd_word",    T_NSEQ, 1'b0, 32'h10, 3'b010, 32'h0,        3'b000);
        applyStimulus("wr_byte",    T_NSEQ, 1'b1, 32'h11, 3'b000, 32'h0000AA00, 3'b000);
        applyStimulus("wr_half",    T_NSEQ, 1'b1, 32'h12, 3'b001, 32'h12340000, 3'b000);
        applyStimulus("rd_merge",   T_NSEQ, 1'b0, 32'h10, 3'b010, 32'h0,        3'b000);
        applyStimulus("err_align",  T_NSEQ, 1'b1, 32'h12, 3'b010, 32'h55555555, 3'b000);
        applyStimulus("err_size",   T_NSEQ, 1'b0, 32'h20, 3'b011, 32'h0,        3'b000);
        applyStimulus("rd_after_e", T_NSEQ, 1'b0, 32'h10, 3'b010, 32'h0,        3'b000);
        applyStimulus("idle",       T_IDLE, 1'b0, 32'h0,  3'b000, 32'h0,        3'b000);

        saved_word = model[4];
        applyStimulus("wr_abort",   T_NSEQ, 1'b1, 32'h10, 3'b010, 32'hFFFFFFFF, 3'b000);
        hsel_d   = 1'b0;
        htrans_d = T_IDLE;
        @(negedge hclk);
        #1 hreset_n = 1'b0;
        #1;
        checkOutput("rst_async_ready", 32'(ready_m), 32'd1);
        checkOutput("rst_async_resp",  32'(resp_m),  32'd0);
        checkOutput("rst_async_rdata", rdata_m,      32'd0);
        model[4] = saved_word;
        @(posedge hclk);
        @(posedge hclk);
        #1 hreset_n = 1'b1;
        applyStimulus("rd_post_rst", T_NSEQ, 1'b0, 32'h10, 3'b010, 32'h0, 3'b000);
        applyStimulus("idle",        T_IDLE, 1'b0, 32'h0,  3'b000, 32'h0, 3'b000);

        use_ws0 = 1'b1;
        applyStimulus("burst_w1", T_NSEQ, 1'b1, 32'h40, 3'b010, 32'h1, 3'b011);
        applyStimulus("burst_w2", T_SEQ,  1'b1, 32'h44, 3'b010, 32'h2, 3'b011);
        applyStimulus("busy",     T_BUSY, 1'b1, 32'h48, 3'b010, 32'h0, 3'b011);
        applyStimulus("burst_w3", T_SEQ,  1'b1, 32'h48, 3'b010, 32'h3, 3'b011);
        applyStimulus("burst_w4", T_SEQ,  1'b1, 32'h4C, 3'b010, 32'h4, 3'b011);
        for (int i = 0; i < 4; i++) begin
            applyStimulus($sformatf("burst_r%0d", i + 1), (i == 0) ? T_NSEQ : T_SEQ, 1'b0,
                          32'h40 + 32'(4 * i), 3'b010, 32'h0, 3'b011);
        end
        applyStimulus("idle", T_IDLE, 1'b0, 32'h0, 3'b000, 32'h0, 3'b000);
        applyStimulus("idle", T_IDLE, 1'b0, 32'h0, 3'b000, 32'h0, 3'b000);

        checkOutput("sb_drain", 32'(sb.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
        $finish;
    end

endmodule
